exp7_detector_jogada: RTL and testbench

//  Input stage between the player's push-buttons and exp7_unidade_controle.
//  - Synchronises and debounces the raw button vector.
//  - Validates one-hot presses and emits a single-cycle jogada_feita pulse.
//  - Holds the accepted code in jogada for the datapath comparator / memory write.
//  - Optionally derives the pausa_jogo level from a dedicated pause button.

---
 rtl/exp7_detector_jogada_pkg.sv | 17 +
 rtl/exp7_sincronizador.sv | 27 ++
 rtl/exp7_detector_jogada.sv | 170 +++++++++++++++++
 tb/tb_exp7_detector_jogada.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exp7_detector_jogada_pkg.sv
// Shared definitions for the play-button input stage: state codes and default timing.
package exp7_detector_jogada_pkg;

  localparam int unsigned N_BOTOES_DEF   = 4;
  localparam int unsigned DEB_CICLOS_DEF = 50000;  // 1 ms at 50 MHz
  localparam int unsigned DEB_CICLOS_SIM = 4;      // short debounce for simulation builds
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned ESTADO_W       = 3;

  typedef enum logic [ESTADO_W-1:0] {
    OCIOSO = 3'd0,
    FILTRA = 3'd1,
    EMITE  = 3'd2,
    SOLTA  = 3'd3
  } estado_t;

endpackage

// File: rtl/exp7_sincronizador.sv
// Parametric-width two-flop synchroniser for asynchronous button inputs.
module exp7_sincronizador #(
  parameter int unsigned W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture; reset clears both stages.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/exp7_detector_jogada.sv
// Play detector: synchronises and debounces the buttons, accepts one-hot presses
// as a single-cycle jogada_feita pulse and holds the accepted code in jogada.
// Optional pause button support is enabled by defining PAUSA_BOTAO_EN.
module exp7_detector_jogada
  import exp7_detector_jogada_pkg::*;
#(
  parameter int unsigned N_BOTOES   = N_BOTOES_DEF,
  parameter int unsigned DEB_CICLOS = DEB_CICLOS_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                habilita,
  input  logic                pausa_botao,
  output logic                jogada_feita,
  output logic [N_BOTOES-1:0] jogada,
  output logic                pausa_jogo,
  output logic [ESTADO_W-1:0] db_estado
);

  localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEB_CICLOS - 1);

  logic [N_BOTOES-1:0] bsync;
  logic [N_BOTOES-1:0] amostra_q, amostra_d;
  logic [N_BOTOES-1:0] amostra_menos1;
  logic                amostra_onehot;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic                jogada_feita_q, jogada_feita_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                pausa_ativa;
  estado_t             estado_q, estado_d;

  exp7_sincronizador #(.W(N_BOTOES)) u_sinc_botoes (
    .clock (clock),
    .reset (reset),
    .d_i   (botoes),
    .q_o   (bsync)
  );

  // One-hot test: non-zero with a single bit set.
  assign amostra_menos1 = amostra_q - N_BOTOES'(1);
  assign amostra_onehot = (amostra_q != '0) && ((amostra_q & amostra_menos1) == '0);

  // State, counter, sample and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q       <= OCIOSO;
      cnt_q          <= '0;
      amostra_q      <= '0;
      jogada_q       <= '0;
      jogada_feita_q <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      cnt_q          <= cnt_d;
      amostra_q      <= amostra_d;
      jogada_q       <= jogada_d;
      jogada_feita_q <= jogada_feita_d;
    end
  end

  // Next-state: debounce the press, accept it once, then wait for a stable release.
  always_comb begin
    estado_d       = estado_q;
    cnt_d          = cnt_q;
    amostra_d      = amostra_q;
    jogada_d       = jogada_q;
    jogada_feita_d = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (bsync != '0) begin
          estado_d  = FILTRA;
          amostra_d = bsync;
          cnt_d     = '0;
        end
      end
      FILTRA: begin
        if (bsync == '0) begin
          estado_d = OCIOSO;
        end else if (bsync != amostra_q) begin
          amostra_d = bsync;
          cnt_d     = '0;
        end else if (cnt_q == CNT_FIM) begin
          estado_d = EMITE;
          // habilita and pause are sampled only here; chords are consumed silently
          if (amostra_onehot && habilita && !pausa_ativa) begin
            jogada_d       = amostra_q;
            jogada_feita_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EMITE: begin
        estado_d = SOLTA;
        cnt_d    = '0;
      end
      SOLTA: begin
        if (bsync != '0) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_FIM) begin
          estado_d = OCIOSO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        estado_d = OCIOSO;
        cnt_d    = '0;
      end
    endcase
  end

`ifdef PAUSA_BOTAO_EN
  logic             psync;
  logic             pnivel_q, pnivel_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             pausa_q, pausa_d;

  exp7_sincronizador #(.W(1)) u_sinc_pausa (
    .clock (clock),
    .reset (reset),
    .d_i   (pausa_botao),
    .q_o   (psync)
  );

  // Pause button debounce level and toggle register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pnivel_q <= 1'b0;
      pcnt_q   <= '0;
      pausa_q  <= 1'b0;
    end else begin
      pnivel_q <= pnivel_d;
      pcnt_q   <= pcnt_d;
      pausa_q  <= pausa_d;
    end
  end

  // Level follows psync after DEB_CICLOS differing cycles; each rising level toggles pause.
  always_comb begin
    pnivel_d = pnivel_q;
    pcnt_d   = pcnt_q;
    pausa_d  = pausa_q;
    if (psync == pnivel_q) begin
      pcnt_d = '0;
    end else if (pcnt_q == CNT_FIM) begin
      pnivel_d = psync;
      pcnt_d   = '0;
      if (psync) begin
        pausa_d = ~pausa_q;
      end
    end else begin
      pcnt_d = pcnt_q + CNT_W'(1);
    end
  end

  assign pausa_ativa = pausa_q;
`else
  logic unused_pausa_botao;
  assign unused_pausa_botao = pausa_botao;
  assign pausa_ativa        = 1'b0;
`endif

  assign jogada_feita = jogada_feita_q;
  assign jogada       = jogada_q;
  assign pausa_jogo   = pausa_ativa;
  assign db_estado    = estado_q;

endmodule

// File: tb/tb_exp7_detector_jogada.sv
// Self-checking bench for exp7_detector_jogada with a short debounce window.
module tb_exp7_detector_jogada;

  localparam int unsigned N   = 4;
  localparam int unsigned DEB = 4;
`ifdef PAUSA_BOTAO_EN
  localparam bit PAUSA_EN = 1'b1;
`else
  localparam bit PAUSA_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [N-1:0] botoes;
  logic         habilita;
  logic         pausa_botao;
  logic         jogada_feita;
  logic [N-1:0] jogada;
  logic         pausa_jogo;
  logic [2:0]   db_estado;

  exp7_detector_jogada #(.N_BOTOES(N), .DEB_CICLOS(DEB), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes       (botoes),
    .habilita     (habilita),
    .pausa_botao  (pausa_botao),
    .jogada_feita (jogada_feita),
    .jogada       (jogada),
    .pausa_jogo   (pausa_jogo),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int pulses = 0;
  int pulse_edge = -1;

  // Reference model: run-length view of the synchronised button stream.
  logic [N-1:0] h1, h2, run_val, exp_jog;
  int           run_len, zero_len, pdiff;
  bit           armed, skip, exp_jf, exp_emite, exp_pausa;
  logic         ph1, ph2, plevel;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    h1 = '0; h2 = '0; run_val = '0; run_len = 0; zero_len = 0;
    armed = 1'b1; skip = 1'b0; exp_jf = 1'b0; exp_emite = 1'b0; exp_jog = '0;
    ph1 = 1'b0; ph2 = 1'b0; plevel = 1'b0; pdiff = 0; exp_pausa = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] s;
    logic         ps;
    if (reset) begin
      model_reset();
      return;
    end
    s = h2; h2 = h1; h1 = botoes;
    ps = ph2; ph2 = ph1; ph1 = pausa_botao;
    exp_jf = 1'b0;
    exp_emite = 1'b0;
    if (armed) begin
      if (run_len > 0 && s == run_val) run_len++;
      else begin
        run_val = s;
        run_len = 1;
      end
      // A press is taken once the same non-zero value has been seen DEB+1 edges in a row
      if (run_val != '0 && run_len == DEB + 1) begin
        exp_emite = 1'b1;
        if ($countones(run_val) == 1 && habilita && !exp_pausa) begin
          exp_jf = 1'b1;
          exp_jog = run_val;
        end
        armed = 1'b0;
        skip = 1'b1;
        zero_len = 0;
      end
    end else if (skip) begin
      skip = 1'b0;
    end else begin
      zero_len = (s == '0) ? zero_len + 1 : 0;
      if (zero_len == DEB) begin
        armed = 1'b1;
        run_len = 0;
      end
    end
    if (PAUSA_EN) begin
      if (ps != plevel) begin
        pdiff++;
        if (pdiff == DEB) begin
          plevel = ps;
          pdiff = 0;
          if (plevel) exp_pausa = ~exp_pausa;
        end
      end else begin
        pdiff = 0;
      end
    end
  endtask

  // One clock: model steps on the rising edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clock);
    model_edge();
    edge_n++;
    @(negedge clock);
    check("jogada_feita", 32'(jogada_feita), 32'(exp_jf));
    check("jogada", 32'(jogada), 32'(exp_jog));
    check("pausa_jogo", 32'(pausa_jogo), 32'(exp_pausa));
    check("emite_estado", 32'(db_estado == 3'd2), 32'(exp_emite));
    if (jogada_feita) begin
      pulses++;
      pulse_edge = edge_n;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_window();
    edge_n = 0;
    pulses = 0;
    pulse_edge = -1;
  endtask

  initial begin
    reset = 1'b1; botoes = '0; habilita = 1'b1; pausa_botao = 1'b0;
    model_reset();
    run(2);
    check("rst_estado", 32'(db_estado), 32'd0);
    check("rst_jogada", 32'(jogada), 32'd0);
    reset = 1'b0;
    run(5);

    // Clean press held a long time: one pulse after edge DEB+3
    botoes = 4'b0100; start_window();
    run(100);
    check("t1_pulsos", 32'(pulses), 32'd1);
    check("t1_latencia", 32'(pulse_edge), 32'(DEB + 3));
    check("t1_jogada", 32'(jogada), 32'b0100);
    botoes = '0; run(10);

    // Bouncing press settles on 0010
    for (int i = 0; i < 4; i++) begin
      botoes = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      run(2);
    end
    botoes = 4'b0010; start_window();
    run(20);
    check("t2_pulsos", 32'(pulses), 32'd1);
    check("t2_latencia", 32'(pulse_edge), 32'(DEB + 3));
    check("t2_jogada", 32'(jogada), 32'b0010);
    botoes = '0; run(10);

    // Chord rejected, then single button accepted
    botoes = 4'b0011; start_window();
    run(20);
    check("t3_acorde", 32'(pulses), 32'd0);
    check("t3_jogada_mantida", 32'(jogada), 32'b0010);
    botoes = '0; run(10);
    botoes = 4'b0001; start_window();
    run(15);
    check("t3_pulsos", 32'(pulses), 32'd1);
    check("t3_jogada", 32'(jogada), 32'b0001);
    botoes = '0; run(10);

    // Disabled press, then enabled press
    habilita = 1'b0; botoes = 4'b1000; start_window();
    run(15);
    check("t4_desabilitado", 32'(pulses), 32'd0);
    botoes = '0; run(10);
    habilita = 1'b1; botoes = 4'b1000; start_window();
    run(15);
    check("t4_pulsos", 32'(pulses), 32'd1);
    check("t4_jogada", 32'(jogada), 32'b1000);
    botoes = '0; run(10);

    // Reset during filtering discards the press
    botoes = 4'b0100;
    run(6);
    check("t5_filtra", 32'(db_estado), 32'd1);
    reset = 1'b1; model_reset();
    #1;
    check("t5_rst_estado", 32'(db_estado), 32'd0);
    check("t5_rst_jogada", 32'(jogada), 32'd0);
    check("t5_rst_pulso", 32'(jogada_feita), 32'd0);
    run(2);
    reset = 1'b0; start_window();
    run(20);
    check("t5_pulsos", 32'(pulses), 32'd1);
    check("t5_latencia", 32'(pulse_edge), 32'(DEB + 3));
    check("t5_jogada", 32'(jogada), 32'b0100);
    botoes = '0; run(10);

    // Pause toggling and suppression
    pausa_botao = 1'b1; run(10);
    pausa_botao = 1'b0; run(10);
    check("t6_pausa_on", 32'(pausa_jogo), 32'(PAUSA_EN));
    botoes = 4'b0001; start_window();
    run(15);
    check("t6_suprimido", 32'(pulses), PAUSA_EN ? 32'd0 : 32'd1);
    botoes = '0; run(10);
    pausa_botao = 1'b1; run(10);
    pausa_botao = 1'b0; run(10);
    check("t6_pausa_off", 32'(pausa_jogo), 32'd0);
    botoes = 4'b0001; start_window();
    run(15);
    check("t6_pulsos", 32'(pulses), 32'd1);
    botoes = '0; run(10);

    // Random traffic against the model
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 3))
        0:       botoes = '0;
        3:       botoes = 4'($urandom_range(0, 15));
        default: botoes = 4'(1 << $urandom_range(0, 3));
      endcase
      habilita = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) pausa_botao = ~pausa_botao;
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1; model_reset();
        run(1);
        reset = 1'b0;
      end
      run(int'($urandom_range(1, 12)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
